// File: rtl/qpi_mem_arbiter_if.sv
// QPI memory request bus: a requester (master) issues bursts and a memory
// side (slave) answers with word strobes, read data and an idle flag.
interface qpi_mem_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic              do_read;
    logic              do_write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              next_word;
    logic              is_idle;

    modport master (
        output do_read, do_write, addr, wdata,
        input  rdata, next_word, is_idle
    );

    modport slave (
        input  do_read, do_write, addr, wdata,
        output rdata, next_word, is_idle
    );
endinterface

// File: rtl/qpi_mem_arbiter.sv
// Two-requester arbiter in front of one QPI memory port. A grant is held for
// a whole burst; after release the arbiter drains until the memory is idle
// before arbitrating again, so downstream only ever sees complete bursts.
module qpi_mem_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int ADDR_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    qpi_mem_arbiter_if.slave      m0,
    qpi_mem_arbiter_if.slave      m1,
    qpi_mem_arbiter_if.master     qpi,
    output logic [1:0]            arb_owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;    // 1: m1 was served last
    logic              sel_q, sel_d;      // current/most recent grantee, kept through DRAIN
    logic [1:0]        owner_q, owner_d;

    logic              req0_s, req1_s;
    logic              win1_s;
    logic              qpi_rd_s, qpi_wr_s;
    logic [ADDR_W-1:0] qpi_addr_s;
    logic [31:0]       qpi_wdata_s;
    logic              m0_nw_s, m1_nw_s;
    logic              idle_s;

    assign req0_s = m0.do_read | m0.do_write;
    assign req1_s = m1.do_read | m1.do_write;

    // Pick the winner: a lone requester wins; a tie goes to the master not
    // served last (round robin) or always to m0 (fixed priority).
    always_comb begin
        win1_s = 1'b0;
        if (req0_s && req1_s) begin
            if (ROUND_ROBIN != 0) begin
                win1_s = ~last_q;
            end else begin
                win1_s = 1'b0;
            end
        end else begin
            win1_s = req1_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold grant until release, drain.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (qpi.is_idle && (req0_s || req1_s)) begin
                    sel_d   = win1_s;
                    state_d = win1_s ? ST_GRANT1 : ST_GRANT0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT0: begin
                if (!req0_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_GRANT0;
                end
            end
            ST_GRANT1: begin
                if (!req1_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_GRANT1;
                end
            end
            ST_DRAIN: begin
                if (qpi.is_idle) begin
                    state_d = ST_IDLE;
                    last_d  = sel_q;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Owner code follows the state being entered so arb_owner is registered
    // yet aligned with the grant states.
    always_comb begin
        owner_d = 2'b00;
        case (state_d)
            ST_GRANT0: owner_d = 2'b01;
            ST_GRANT1: owner_d = 2'b10;
            default:   owner_d = 2'b00;
        endcase
    end

    // Downstream mux and strobe routing; requests and strobes are cut while
    // rst is high, even mid-burst. Write takes precedence over read.
    always_comb begin
        qpi_rd_s    = 1'b0;
        qpi_wr_s    = 1'b0;
        qpi_addr_s  = {ADDR_W{1'b0}};
        qpi_wdata_s = 32'h0000_0000;
        m0_nw_s     = 1'b0;
        m1_nw_s     = 1'b0;
        case (state_q)
            ST_GRANT0: begin
                qpi_wr_s    = m0.do_write & ~rst;
                qpi_rd_s    = m0.do_read & ~m0.do_write & ~rst;
                qpi_addr_s  = m0.addr;
                qpi_wdata_s = m0.wdata;
                m0_nw_s     = qpi.next_word & ~rst;
            end
            ST_GRANT1: begin
                qpi_wr_s    = m1.do_write & ~rst;
                qpi_rd_s    = m1.do_read & ~m1.do_write & ~rst;
                qpi_addr_s  = m1.addr;
                qpi_wdata_s = m1.wdata;
                m1_nw_s     = qpi.next_word & ~rst;
            end
            default: begin
                qpi_rd_s = 1'b0;
                qpi_wr_s = 1'b0;
            end
        endcase
    end

    assign idle_s        = (state_q == ST_IDLE) & qpi.is_idle;

    assign qpi.do_read   = qpi_rd_s;
    assign qpi.do_write  = qpi_wr_s;
    assign qpi.addr      = qpi_addr_s;
    assign qpi.wdata     = qpi_wdata_s;
    assign m0.rdata      = qpi.rdata;
    assign m1.rdata      = qpi.rdata;
    assign m0.next_word  = m0_nw_s;
    assign m1.next_word  = m1_nw_s;
    assign m0.is_idle    = idle_s;
    assign m1.is_idle    = idle_s;
    assign arb_owner     = owner_q;

    // State, fairness and owner registers; reset makes m0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            owner_q <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_qpi_mem_arbiter.sv
// Bench for qpi_mem_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus; word strobes are scored against a per-master queue.
module tb_qpi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_rd, m0_wr, m1_rd, m1_wr;
    logic [23:0] m0_a, m1_a;
    logic [31:0] m0_wd, m1_wd;
    logic [31:0] q_rdata;
    logic        q_nw, q_idle;
    logic [1:0]  arb_rr, arb_fp;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] d;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    qpi_mem_arbiter_if #(.ADDR_W(24)) rr_m0 ();
    qpi_mem_arbiter_if #(.ADDR_W(24)) rr_m1 ();
    qpi_mem_arbiter_if #(.ADDR_W(24)) rr_q ();
    qpi_mem_arbiter_if #(.ADDR_W(24)) fp_m0 ();
    qpi_mem_arbiter_if #(.ADDR_W(24)) fp_m1 ();
    qpi_mem_arbiter_if #(.ADDR_W(24)) fp_q ();

    assign rr_m0.do_read  = m0_rd;  assign fp_m0.do_read  = m0_rd;
    assign rr_m0.do_write = m0_wr;  assign fp_m0.do_write = m0_wr;
    assign rr_m0.addr     = m0_a;   assign fp_m0.addr     = m0_a;
    assign rr_m0.wdata    = m0_wd;  assign fp_m0.wdata    = m0_wd;
    assign rr_m1.do_read  = m1_rd;  assign fp_m1.do_read  = m1_rd;
    assign rr_m1.do_write = m1_wr;  assign fp_m1.do_write = m1_wr;
    assign rr_m1.addr     = m1_a;   assign fp_m1.addr     = m1_a;
    assign rr_m1.wdata    = m1_wd;  assign fp_m1.wdata    = m1_wd;
    assign rr_q.rdata     = q_rdata; assign fp_q.rdata    = q_rdata;
    assign rr_q.next_word = q_nw;   assign fp_q.next_word = q_nw;
    assign rr_q.is_idle   = q_idle; assign fp_q.is_idle   = q_idle;

    qpi_mem_arbiter #(.ROUND_ROBIN(1), .ADDR_W(24)) dut_rr (
        .clk(clk), .rst(rst), .m0(rr_m0), .m1(rr_m1), .qpi(rr_q), .arb_owner(arb_rr)
    );

    qpi_mem_arbiter #(.ROUND_ROBIN(0), .ADDR_W(24)) dut_fp (
        .clk(clk), .rst(rst), .m0(fp_m0), .m1(fp_m1), .qpi(fp_q), .arb_owner(arb_fp)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // One downstream word strobe followed by a gap cycle; the expected
    // payload is queued for the master that should receive it.
    task automatic strobe(input bit to_m1, input bit is_wr, input logic [31:0] d);
        exp_t e;
        nxt();
        q_nw    = 1'b1;
        q_rdata = is_wr ? 32'h0 : d;
        e.is_wr = is_wr;
        e.d     = d;
        if (to_m1) q1.push_back(e);
        else       q0.push_back(e);
        nxt();
        q_nw = 1'b0;
    endtask

    // Scoreboard: every forwarded strobe must match a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rr_m0.next_word === 1'b1) begin
            if (q0.size() == 0) begin
                chk("m0_unexpected_next_word", 64'd1, 64'd0);
            end else begin
                e = q0.pop_front();
                chk("m0_word", e.is_wr ? {32'h0, rr_q.wdata} : {32'h0, rr_m0.rdata}, {32'h0, e.d});
            end
        end
        if (rr_m1.next_word === 1'b1) begin
            if (q1.size() == 0) begin
                chk("m1_unexpected_next_word", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                chk("m1_word", e.is_wr ? {32'h0, rr_q.wdata} : {32'h0, rr_m1.rdata}, {32'h0, e.d});
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
        m0_a = 24'h0; m1_a = 24'h0; m0_wd = 32'h0; m1_wd = 32'h0;
        q_rdata = 32'h0; q_nw = 1'b0; q_idle = 1'b1;

        // reset state
        nxt(); smp();
        chk("rst_do_read", rr_q.do_read, 1'b0);
        chk("rst_owner", arb_rr, 2'b00);
        nxt(); rst = 1'b0; smp();
        chk("post_rst_owner", arb_rr, 2'b00);
        chk("post_rst_m0_idle", rr_m0.is_idle, 1'b1);

        // single read of 4 words from m0
        nxt(); m0_rd = 1'b1; m0_a = 24'h000100; smp();
        chk("rd_lat_cycle0", rr_q.do_read, 1'b0);
        nxt(); q_idle = 1'b0; smp();
        chk("rd_lat_cycle1", rr_q.do_read, 1'b1);
        chk("rd_addr", rr_q.addr, 24'h000100);
        chk("rd_owner", arb_rr, 2'b01);
        for (int k = 0; k < 4; k++) begin
            strobe(1'b0, 1'b0, 32'h11111111 * 32'(k + 1));
        end
        m0_rd = 1'b0; smp();
        chk("rd_release_do_read", rr_q.do_read, 1'b0);
        nxt(); smp();
        chk("rd_drain_owner", arb_rr, 2'b00);
        chk("rd_drain_m0_idle", rr_m0.is_idle, 1'b0);
        nxt(); q_idle = 1'b1; smp();
        nxt(); smp();
        chk("rd_back_idle", rr_m0.is_idle, 1'b1);

        // stray strobe in IDLE is not forwarded
        nxt(); q_nw = 1'b1; q_rdata = 32'h5A5A5A5A; smp();
        chk("stray_m0_nw", rr_m0.next_word, 1'b0);
        chk("stray_m1_nw", rr_m1.next_word, 1'b0);
        nxt(); q_nw = 1'b0;

        // fresh reset, then ties
        rst = 1'b1; smp(); nxt(); rst = 1'b0; smp();
        nxt(); m0_rd = 1'b1; m0_a = 24'h000200; m1_rd = 1'b1; m1_a = 24'h000300; smp();
        chk("tie_m1_idle", rr_m1.is_idle, 1'b1);
        nxt(); smp();
        chk("tie1_rr_owner", arb_rr, 2'b01);
        chk("tie1_fp_owner", arb_fp, 2'b01);
        chk("tie1_addr", rr_q.addr, 24'h000200);
        chk("tie1_m1_idle", rr_m1.is_idle, 1'b0);
        strobe(1'b0, 1'b0, 32'hA0A0A0A0);
        m0_rd = 1'b0; smp();
        chk("tie1_release", rr_q.do_read, 1'b0);
        nxt(); m0_rd = 1'b1; m0_a = 24'h000210; smp();
        chk("tie1_drain_owner", arb_rr, 2'b00);
        chk("tie1_drain_do_read", rr_q.do_read, 1'b0);
        nxt(); smp();
        chk("tie_rearb_idle", rr_m0.is_idle, 1'b1);
        nxt(); smp();
        chk("tie2_rr_owner", arb_rr, 2'b10);
        chk("tie2_fp_owner", arb_fp, 2'b01);
        chk("tie2_addr", rr_q.addr, 24'h000300);
        strobe(1'b1, 1'b0, 32'hB0B0B0B0);
        m1_rd = 1'b0; smp();
        nxt(); m1_rd = 1'b1; m1_a = 24'h000310; smp();
        chk("tie2_drain_owner", arb_rr, 2'b00);
        chk("fp_hold_m0_a", arb_fp, 2'b01);
        nxt(); smp();
        nxt(); smp();
        chk("tie3_rr_owner", arb_rr, 2'b01);
        chk("tie3_addr", rr_q.addr, 24'h000210);
        chk("fp_hold_m0_b", arb_fp, 2'b01);
        nxt(); m0_rd = 1'b0; smp();
        nxt(); smp();
        nxt(); smp();
        nxt(); smp();
        chk("m1_alone_rr_owner", arb_rr, 2'b10);
        chk("m1_alone_fp_owner", arb_fp, 2'b10);
        chk("m1_alone_addr", rr_q.addr, 24'h000310);
        nxt(); m1_rd = 1'b0; smp();
        nxt(); smp();
        nxt(); smp();

        // write passthrough on m1 (read also high: write wins)
        nxt(); m1_rd = 1'b1; m1_wr = 1'b1; m1_a = 24'hABCDE0; m1_wd = 32'hDEADBEEF; smp();
        nxt(); smp();
        chk("wr_do_write", rr_q.do_write, 1'b1);
        chk("wr_do_read_suppressed", rr_q.do_read, 1'b0);
        chk("wr_addr", rr_q.addr, 24'hABCDE0);
        chk("wr_wdata0", rr_q.wdata, 32'hDEADBEEF);
        chk("wr_owner", arb_rr, 2'b10);
        chk("wr_m0_idle_a", rr_m0.is_idle, 1'b0);
        strobe(1'b1, 1'b1, 32'hDEADBEEF);
        m1_wd = 32'hCAFEF00D; smp();
        chk("wr_wdata1", rr_q.wdata, 32'hCAFEF00D);
        chk("wr_m0_idle_b", rr_m0.is_idle, 1'b0);
        strobe(1'b1, 1'b1, 32'hCAFEF00D);
        m1_wr = 1'b0; m1_rd = 1'b0; smp();
        chk("wr_m0_idle_c", rr_m0.is_idle, 1'b0);
        nxt(); smp();
        chk("wr_drain_m0_idle", rr_m0.is_idle, 1'b0);
        nxt(); smp();

        // drain hold while memory stays busy
        nxt(); m0_rd = 1'b1; m0_a = 24'h000400; smp();
        nxt(); m1_rd = 1'b1; m1_a = 24'h000500; q_idle = 1'b0; smp();
        chk("drain_grant_owner", arb_rr, 2'b01);
        nxt(); m0_rd = 1'b0; smp();
        for (int k = 0; k < 5; k++) begin
            nxt(); smp();
            chk("drain_do_read", rr_q.do_read, 1'b0);
            chk("drain_do_write", rr_q.do_write, 1'b0);
            chk("drain_owner", arb_rr, 2'b00);
        end
        nxt(); q_idle = 1'b1; smp();
        chk("drain_last_owner", arb_rr, 2'b00);
        nxt(); smp();
        chk("drain_idle_owner", arb_rr, 2'b00);
        chk("drain_idle_m1", rr_m1.is_idle, 1'b1);
        nxt(); smp();
        chk("drain_m1_owner", arb_rr, 2'b10);
        chk("drain_m1_fp_owner", arb_fp, 2'b10);
        chk("drain_m1_do_read", rr_q.do_read, 1'b1);
        chk("drain_m1_addr", rr_q.addr, 24'h000500);

        // reset in the middle of an m1 burst
        q_idle = 1'b0;
        strobe(1'b1, 1'b0, 32'hC0000001);
        strobe(1'b1, 1'b0, 32'hC0000002);
        rst = 1'b1; q_nw = 1'b1; q_rdata = 32'hC0000003; smp();
        chk("midrst_do_read", rr_q.do_read, 1'b0);
        chk("midrst_do_write", rr_q.do_write, 1'b0);
        chk("midrst_m1_nw", rr_m1.next_word, 1'b0);
        nxt(); rst = 1'b0; q_nw = 1'b0; m1_rd = 1'b0; q_idle = 1'b1;
        m0_rd = 1'b1; m0_a = 24'h000600; smp();
        chk("midrst_owner_rr", arb_rr, 2'b00);
        chk("midrst_owner_fp", arb_fp, 2'b00);
        chk("midrst_m0_idle", rr_m0.is_idle, 1'b1);
        nxt(); smp();
        chk("post_rst_grant_owner", arb_rr, 2'b01);
        chk("post_rst_do_read", rr_q.do_read, 1'b1);
        chk("post_rst_addr", rr_q.addr, 24'h000600);
        strobe(1'b0, 1'b0, 32'h66666666);
        m0_rd = 1'b0;
        nxt(); nxt(); nxt(); smp();

        chk("m0_words_missing", q0.size(), 0);
        chk("m1_words_missing", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/qpi_mem_arbiter.md
Name: qpi_mem_arbiter

Overview:
- Two-port arbiter that shares one QPI memory interface (the sdram adapter's master port) between two requesters, e.g. instruction and data caches.
- Each requester sees an interface identical to the downstream one.
- A grant is held for a whole burst, so the memory sees only well-formed transactions.
- Sits between the cache masters and qpi_sdram_adapter.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate priority after each completed grant; 0 = fixed priority, m0 always wins ties.
- ADDR_W, 24, address width of all ports.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- m0_do_read, m1_do_read  in  1  read request from requester 0/1; held for the whole burst
- m0_do_write, m1_do_write  in  1  write request from requester 0/1; held for the whole burst
- m0_addr, m1_addr  in  ADDR_W  burst start address
- m0_wdata, m1_wdata  in  32  write data; the current word
- m0_rdata, m1_rdata  out  32  read data; both are a copy of qpi_rdata
- m0_next_word, m1_next_word  out  1  word-transfer strobe, routed only to the granted master
- m0_is_idle, m1_is_idle  out  1  a new transaction may start
- qpi_do_read, qpi_do_write  out  1  downstream request
- qpi_addr  out  ADDR_W  downstream address
- qpi_wdata  out  32  downstream write data
- qpi_rdata  in  32  downstream read data
- qpi_next_word  in  1  downstream word strobe
- qpi_is_idle  in  1  downstream idle
- arb_owner  out  2  00 none, 01 m0, 10 m1; debug/perf

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - Synchronous active-high reset rst; state is sampled on the rising edge.
- Requester protocol:
  - Request = do_read | do_write.
  - A master asserts a request and holds it, with addr stable, until it has received all wanted next_word strobes.
  - It then drops the request.
  - Each next_word pulse means one 32-bit word moved: rdata valid that cycle, or wdata consumed.
  - If both do_read and do_write are high, write wins and the read is ignored.
- State machine IDLE / GRANT0 / GRANT1 / DRAIN (registered):
  - IDLE: if qpi_is_idle=1 and any request is present, pick a winner and go to GRANT0 or GRANT1 on the next edge.
    - Single requester: it wins.
    - Both requesting: winner is the master not last served if ROUND_ROBIN=1, else m0.
    - If qpi_is_idle=0, stay in IDLE.
  - GRANTn:
    - Drive qpi_do_read/qpi_do_write/qpi_addr/qpi_wdata combinationally from master n.
    - mn_next_word = qpi_next_word; the other master's next_word = 0.
    - When master n's request is low, go to DRAIN. qpi_do_* are already low that cycle because they are muxed from n.
  - DRAIN:
    - qpi_do_* = 0.
    - Wait for qpi_is_idle=1, then go to IDLE and set last_served = n.
- Latency:
  - A request seen in IDLE (with qpi_is_idle=1) reaches qpi_do_* one cycle later.
  - Release costs at least 1 DRAIN cycle plus 1 IDLE arbitration cycle before the next grant.
- Outputs per state:
  - Outside GRANTn: qpi_do_read = qpi_do_write = 0; qpi_addr and qpi_wdata = 0.
  - mN_is_idle = (state==IDLE) & qpi_is_idle. It is 0 for both masters in GRANTx and DRAIN.
  - arb_owner is registered: 01 in GRANT0, 10 in GRANT1, 00 otherwise.
- Simultaneous events:
  - A request arriving in the same cycle the owner releases is not granted until the IDLE cycle after DRAIN completes.
  - A non-granted master's request is held off indefinitely; with ROUND_ROBIN=1 it is guaranteed the next grant.
- Stray strobe: qpi_next_word in IDLE/DRAIN is ignored; both mN_next_word stay 0.
- Reset:
  - State → IDLE, last_served → m1 (so m0 wins first tie), arb_owner → 00.
  - While rst=1, qpi_do_read/qpi_do_write are forced 0 combinationally. This holds mid-burst too.
  - All mN_next_word = 0 during reset.

Test Plan:
- Single read: m0_do_read=1, addr=0x000100, memory returns 4 strobes with rdata 0x11111111..0x44444444, then m0 drops → qpi_do_read rises 1 cycle after request; m0 gets 4 next_word with matching rdata; m1_next_word stays 0; arb_owner 01 then 00.
- Tie, round robin: both request in the same cycle after reset → m0 granted first. After m0 releases, m1 (still requesting) is granted. On the next tie, m0 wins again.
- ROUND_ROBIN=0: m0 and m1 repeatedly tie → m0 wins every time. m1 is granted only in a cycle where m0 is not requesting.
- Write passthrough: m1_do_write=1, addr=0xABCDE0, wdata sequence 0xDEADBEEF, 0xCAFEF00D → qpi_addr=0xABCDE0 and qpi_wdata follow m1 exactly; m1 sees 2 next_word strobes; m0_is_idle=0 throughout.
- Drain hold: owner releases while qpi_is_idle=0 for 5 cycles, and m1 is requesting → state stays DRAIN, no qpi_do_* asserted, m1 granted 2 cycles after qpi_is_idle rises.
- Reset mid-burst: assert rst during GRANT1 after 2 of 8 words → qpi_do_* are 0 in the rst cycle; arb_owner=00 after the edge; no next_word strobes are forwarded; a new m0 request after reset is granted normally.
